// File: rtl/gray_step_arbiter.sv
// gray_step_arbiter
//   Round-robin arbiter and sequencer for a shared Gray-coded up/down
//   position counter. Two requesters ask for a move of N steps in a chosen
//   direction. One request is granted at a time, and the position advances by
//   exactly one Gray step per clock until the move completes. A one-cycle done
//   pulse then goes back to the requester that owned the move.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req0/dir0/steps0  requester 0: level request, direction (1=up), step count
//   req1/dir1/steps1  requester 1: same fields as requester 0
//   gnt0/gnt1         one-cycle grant pulse; the request fields are captured
//   done0/done1       one-cycle completion pulse to the owner of the move
//   busy              high from the grant cycle through the done cycle
//   step_en           high in each cycle in which gray has just moved one step
//   gray              current position in Gray code
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no move in progress; arbitrate and capture a request
// RUN     | apply one step per clock until rem reaches zero
// DONE    | pulse done to the owner, record it as last served, then IDLE
module gray_step_arbiter #(
  parameter int WIDTH = 4,
  parameter int STEPW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             dir0,
  input  logic [STEPW-1:0] steps0,
  input  logic             req1,
  input  logic             dir1,
  input  logic [STEPW-1:0] steps1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic             step_en,
  output logic [WIDTH-1:0] gray
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic [STEPW-1:0] r_rem;
  logic             r_owner;
  logic             r_dir;
  logic             r_last;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic             r_busy;
  logic             r_step_en;

  logic             w_sel_valid;
  logic             w_sel;
  logic             w_sel_dir;
  logic [STEPW-1:0] w_sel_steps;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;

  // On a tie the requester that was not served last wins.
  assign w_sel_valid = req0 | req1;
  assign w_sel       = (req0 & req1) ? ~r_last : req1;
  assign w_sel_dir   = w_sel ? dir1 : dir0;
  assign w_sel_steps = w_sel ? steps1 : steps0;

  // Modulo 2^WIDTH: up wraps all-ones -> 0, down wraps 0 -> all-ones.
  assign w_bin_nxt  = r_dir ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
  assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bin     <= '0;
      r_gray    <= '0;
      r_rem     <= '0;
      r_owner   <= 1'b0;
      r_dir     <= 1'b0;
      r_last    <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_busy    <= 1'b0;
      r_step_en <= 1'b0;
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_step_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sel_valid) begin
            r_owner <= w_sel;
            r_dir   <= w_sel_dir;
            r_rem   <= w_sel_steps;
            r_gnt0  <= ~w_sel;
            r_gnt1  <= w_sel;
            r_busy  <= 1'b1;
            r_state <= (w_sel_steps != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          r_bin     <= w_bin_nxt;
          r_gray    <= w_gray_nxt;
          r_rem     <= r_rem - STEPW'(1);
          r_step_en <= 1'b1;
          // Raise done together with the last step so they share a cycle.
          if (r_rem == STEPW'(1)) begin
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // A zero-step move enters DONE straight from the grant, with done
          // not yet raised; spend one extra cycle here to pulse it.
          if (r_done0 | r_done1) begin
            r_busy  <= 1'b0;
            r_last  <= r_owner;
            r_state <= ST_IDLE;
          end else begin
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign done0   = r_done0;
  assign done1   = r_done1;
  assign busy    = r_busy;
  assign step_en = r_step_en;
  assign gray    = r_gray;

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Directed bench for gray_step_arbiter. Each cycle's observation is packed as
// {gnt0, gnt1, done0, done1, busy, step_en, gray[3:0]}.
module tb_gray_step_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       dir0 = 1'b0;
  logic [3:0] steps0 = 4'd0;
  logic       req1 = 1'b0;
  logic       dir1 = 1'b0;
  logic [3:0] steps1 = 4'd0;
  logic       gnt0, gnt1, done0, done1, busy, step_en;
  logic [3:0] gray;
  logic [9:0] obs;

  int pass_cnt = 0;
  int total_cnt = 0;

  gray_step_arbiter #(.WIDTH(4), .STEPW(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .dir0(dir0), .steps0(steps0),
    .req1(req1), .dir1(dir1), .steps1(steps1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .busy(busy), .step_en(step_en), .gray(gray)
  );

  assign obs = {gnt0, gnt1, done0, done1, busy, step_en, gray};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present one request for a single sampling edge; returns in the grant cycle.
  task automatic issue(input bit sel, input bit d, input logic [3:0] s);
    if (sel) begin
      req1 = 1'b1; dir1 = d; steps1 = s;
    end else begin
      req0 = 1'b1; dir0 = d; steps0 = s;
    end
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (obs !== 10'b0) $display("FAIL reset_hold: got %b expected %b", obs, 10'b0);
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if (obs !== 10'b0) $display("FAIL reset_idle cyc %0d: got %b expected %b", i, obs, 10'b0);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_up();
    logic [9:0] e [5] = '{10'b10_00_10_0000, 10'b00_00_11_0001, 10'b00_00_11_0011,
                          10'b00_10_11_0010, 10'b00_00_00_0010};
    int busy_cycles = 0;
    do_reset();
    issue(1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      if (busy === 1'b1) busy_cycles++;
      total_cnt++;
      if (obs !== e[i]) $display("FAIL single_up cyc %0d: got %b expected %b", i, obs, e[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy_cycles !== 4) $display("FAIL single_up_busy_len: got %0d expected %0d", busy_cycles, 4);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [9:0] e [12] = '{10'b10_00_10_0000, 10'b00_10_11_0001, 10'b00_00_00_0001,
                           10'b01_00_10_0001, 10'b00_01_11_0011, 10'b00_00_00_0011,
                           10'b10_00_10_0011, 10'b00_10_11_0010, 10'b00_00_00_0010,
                           10'b01_00_10_0010, 10'b00_01_11_0110, 10'b00_00_00_0110};
    do_reset();
    req0 = 1'b1; dir0 = 1'b1; steps0 = 4'd1;
    req1 = 1'b1; dir1 = 1'b1; steps1 = 4'd1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 10) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      total_cnt++;
      if (obs !== e[i]) $display("FAIL round_robin cyc %0d: got %b expected %b", i, obs, e[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    logic [9:0] a [3] = '{10'b01_00_10_0000, 10'b00_01_11_1000, 10'b00_00_00_1000};
    logic [9:0] b [3] = '{10'b01_00_10_1000, 10'b00_01_11_0000, 10'b00_00_00_0000};
    logic [9:0] c [3] = '{10'b10_00_10_0000, 10'b00_10_11_1000, 10'b00_00_00_1000};
    logic [9:0] d [4] = '{10'b10_00_10_1000, 10'b00_00_11_0000, 10'b00_10_11_0001,
                          10'b00_00_00_0001};
    do_reset();
    issue(1'b1, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      total_cnt++;
      if (obs !== a[i]) $display("FAIL wrap_down cyc %0d: got %b expected %b", i, obs, a[i]);
      else pass_cnt++;
    end
    issue(1'b1, 1'b1, 4'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      total_cnt++;
      if (obs !== b[i]) $display("FAIL wrap_up cyc %0d: got %b expected %b", i, obs, b[i]);
      else pass_cnt++;
    end
    issue(1'b0, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      total_cnt++;
      if (obs !== c[i]) $display("FAIL wrap_to15 cyc %0d: got %b expected %b", i, obs, c[i]);
      else pass_cnt++;
    end
    issue(1'b0, 1'b1, 4'd2);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      total_cnt++;
      if (obs !== d[i]) $display("FAIL wrap_up2 cyc %0d: got %b expected %b", i, obs, d[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_and_ignored();
    logic [9:0] z [4] = '{10'b10_00_10_0000, 10'b00_10_10_0000, 10'b00_00_00_0000,
                          10'b00_00_00_0000};
    logic [9:0] m [6] = '{10'b10_00_10_0000, 10'b00_00_11_0001, 10'b00_00_11_0011,
                          10'b00_00_11_0010, 10'b00_10_11_0110, 10'b00_00_00_0110};
    do_reset();
    issue(1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      total_cnt++;
      if (obs !== z[i]) $display("FAIL zero_step cyc %0d: got %b expected %b", i, obs, z[i]);
      else pass_cnt++;
    end
    issue(1'b0, 1'b1, 4'd4);
    dir0 = 1'b0;
    steps0 = 4'hF;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      total_cnt++;
      if (obs !== m[i]) $display("FAIL ignored_fields cyc %0d: got %b expected %b", i, obs, m[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_move();
    logic [9:0] p [3] = '{10'b10_00_10_0000, 10'b00_10_11_0001, 10'b00_00_00_0001};
    logic [9:0] q [4] = '{10'b10_00_10_0001, 10'b00_00_11_0011, 10'b00_00_11_0010,
                          10'b00_00_11_0110};
    logic [9:0] t [3] = '{10'b10_00_10_0000, 10'b00_10_11_0001, 10'b00_00_00_0001};
    do_reset();
    // Serve requester 0 first so only the reset can make it win the next tie.
    issue(1'b0, 1'b1, 4'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      total_cnt++;
      if (obs !== p[i]) $display("FAIL mid_pre cyc %0d: got %b expected %b", i, obs, p[i]);
      else pass_cnt++;
    end
    issue(1'b0, 1'b1, 4'd8);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      total_cnt++;
      if (obs !== q[i]) $display("FAIL mid_run cyc %0d: got %b expected %b", i, obs, q[i]);
      else pass_cnt++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (obs !== 10'b0) $display("FAIL mid_reset: got %b expected %b", obs, 10'b0);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (obs !== 10'b0) $display("FAIL mid_no_done cyc %0d: got %b expected %b", i, obs, 10'b0);
      else pass_cnt++;
    end
    req0 = 1'b1; dir0 = 1'b1; steps0 = 4'd1;
    req1 = 1'b1; dir1 = 1'b1; steps1 = 4'd1;
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      total_cnt++;
      if (obs !== t[i]) $display("FAIL mid_tie cyc %0d: got %b expected %b", i, obs, t[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_round_robin();
    test_wrap();
    test_zero_and_ignored();
    test_reset_mid_move();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
